// File: rtl/hwag_cfg_sequencer_if.sv
// Host-side command port of the hwag configuration sequencer: level request,
// one-cycle ack, read data held until the next read completes.
interface hwag_cfg_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );
endinterface

// File: rtl/hwag_cfg_sequencer.sv
// Owns the hwag register bus: boot-loads the default image from ROM, then serves
// single-word host reads/writes. hwag_en stays low until the image is complete.
module hwag_cfg_sequencer #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned INIT_DEPTH = 131
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_start,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_data,
  hwag_cfg_sequencer_if.slave   host,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic                  bus_we,
  output logic                  bus_re,
  input  logic [DATA_W-1:0]     bus_rdata,
  output logic                  init_busy,
  output logic                  init_done,
  output logic                  hwag_en
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(INIT_DEPTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWrite,
    StHWr,
    StHRd,
    StHRdw
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              armed_q, armed_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] haddr_q;
  logic [DATA_W-1:0] hwdata_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;

  // State register. pend resets to 1 so the boot load starts on its own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      armed_q     <= 1'b1;
      pend_q      <= 1'b1;
      done_q      <= 1'b0;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      armed_q     <= armed_d;
      pend_q      <= pend_d;
      done_q      <= done_d;
      bus_addr_q  <= bus_addr;
      bus_wdata_q <= bus_wdata;
      if (accept) begin
        haddr_q  <= host.addr;
        hwdata_q <= host.wdata;
      end
      if (state_q == StHRdw) begin
        rdata_q <= bus_rdata;
      end
    end
  end

  // Next-state logic. A pending init beats the host; a fresh init_start that
  // coincides with a host accept is deferred through pend.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q | init_start;
    done_d  = done_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          state_d = StFetch;
          idx_d   = '0;
          pend_d  = 1'b0;
          done_d  = 1'b0;
        end else if (done_q && host.req && armed_q) begin
          accept  = 1'b1;
          state_d = host.we ? StHWr : StHRd;
        end else if (init_start) begin
          state_d = StFetch;
          idx_d   = '0;
          pend_d  = 1'b0;
          done_d  = 1'b0;
        end
      end
      StFetch: state_d = StWrite;
      StWrite: begin
        if (idx_q == LastIdx) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = StFetch;
        end
      end
      StHWr:   state_d = StIdle;
      StHRd:   state_d = StHRdw;
      StHRdw:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Re-arm only once the host has released req, so a held req issues once.
  always_comb begin
    armed_d = armed_q;
    if (!host.req) begin
      armed_d = 1'b1;
    end else if (accept) begin
      armed_d = 1'b0;
    end
  end

  // Outputs. Bus address/data fall back to their last driven values when idle.
  always_comb begin
    rom_addr   = idx_q;
    init_busy  = 1'b0;
    bus_we     = 1'b0;
    bus_re     = 1'b0;
    bus_addr   = bus_addr_q;
    bus_wdata  = bus_wdata_q;
    host.ack   = 1'b0;
    host.rdata = rdata_q;
    unique case (state_q)
      StFetch: init_busy = 1'b1;
      StWrite: begin
        init_busy = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = idx_q;
        bus_wdata = rom_data;
      end
      StHWr: begin
        bus_we    = 1'b1;
        bus_addr  = haddr_q;
        bus_wdata = hwdata_q;
        host.ack  = 1'b1;
      end
      StHRd: begin
        bus_re   = 1'b1;
        bus_addr = haddr_q;
      end
      StHRdw: begin
        host.ack   = 1'b1;
        host.rdata = bus_rdata;
      end
      default: ;
    endcase
  end

  assign init_done = done_q;
  assign hwag_en   = done_q;

endmodule

// File: doc/hwag_cfg_sequencer.md
Name: hwag_cfg_sequencer

Overview:
Owns the 16-bit hwag configuration register bus and shares it between two requesters.
- Boot loader: copies INIT_DEPTH default words from a ROM into hwag registers 0..INIT_DEPTH-1 after reset or on init_start.
- Host port: SPI-side command decoder doing single-word reads and writes.

Holds hwag_en low until the default image is fully written, so the angle generator never runs on unconfigured registers (min/max capture, HWATHNB, HWACR0, ignition angle).

Parameters:
ADDR_W, 8, register/ROM address width
DATA_W, 16, register data width
INIT_DEPTH, 131, number of ROM words loaded (addresses 0..INIT_DEPTH-1), range 1..2^ADDR_W

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, active-low
init_start  input  1  one-cycle pulse: re-run the boot load
rom_addr  output  ADDR_W  default-table address
rom_data  input  DATA_W  default-table word, valid the cycle after rom_addr
host_req  input  1  host transaction request, level
host_we  input  1  1 = write, 0 = read; sampled at accept
host_addr  input  ADDR_W  sampled at accept
host_wdata  input  DATA_W  sampled at accept
host_ack  output  1  one-cycle completion pulse
host_rdata  output  DATA_W  read result, valid from host_ack, held until next read
bus_addr  output  ADDR_W  register bus address
bus_wdata  output  DATA_W  register bus write data
bus_we  output  1  register write strobe, one cycle per write
bus_re  output  1  register read strobe, one cycle per read
bus_rdata  input  DATA_W  register read data, valid the cycle after bus_re
init_busy  output  1  boot load in progress
init_done  output  1  boot image complete
hwag_en  output  1  angle generator enable, equals init_done

Behaviour:
Reset (rst low):
- All outputs are 0; the index counter is 0 and armed = 1.
- The FSM enters FETCH on the first clock after rst rises, so the load starts automatically.
- rst asserted mid-load or mid-host transaction aborts immediately with no partial strobe. The load then restarts from index 0 after release.

FSM states: IDLE, FETCH, WRITE, H_WR, H_RD, H_RDW.

Boot load:
- FETCH: rom_addr = idx; init_busy = 1.
- WRITE: bus_we = 1, bus_addr = idx, bus_wdata = rom_data.
  - idx == INIT_DEPTH-1: go to IDLE and set init_done/hwag_en the next cycle.
  - Otherwise: idx+1, back to FETCH.
- Two cycles per word, so a full load takes 2*INIT_DEPTH cycles (262 default). idx never wraps.

init_start:
- Accepted only in IDLE. Clears init_done/hwag_en in the same edge, sets idx = 0, goes to FETCH.
- A pulse arriving during a load or host transaction is latched in a pending flag and serviced at the next IDLE.
- Pending init_start has priority over a simultaneous host_req.

Host arbitration:
- Host is served only in IDLE with init_done = 1 and no pending init.
- A host_req during a load stalls (no ack) until the load completes.
- Accept occurs when host_req & armed. Addr, data and we are latched and armed is cleared. armed is set again in any cycle host_req = 0.
- Consequence: a req held high after ack never double-issues; host must drop req for at least 1 cycle between transactions.
- Dropping req after accept does not cancel the transaction.

Host write: accept at edge N → H_WR during cycle N+1 with bus_we = 1 and host_ack = 1 → IDLE.

Host read:
- Accept at N → H_RD at N+1: bus_re = 1.
- H_RDW at N+2: host_rdata <= bus_rdata, host_ack = 1 → IDLE.

Bus ownership and address range:
- bus_we and bus_re are never both 1, and never asserted outside WRITE/H_WR/H_RD.
- bus_addr/bus_wdata hold their last value when idle.
- Host addresses ≥ INIT_DEPTH are passed through unchanged; range checking belongs to the register file.

Test Plan:
1. Release rst with ROM[0]=128, ROM[4]=57, ROM[6]=3839, ROM[63]=7, ROM[129]=3830 → exactly 131 bus_we pulses at addresses 0..130 with matching data; init_done = hwag_en = 1 at cycle 263 after release; no bus_re.
2. host_req write addr 70 data 2 asserted at cycle 10 during load → no ack until after the load; then bus_we at addr 70 data 2 and host_ack in the same cycle, exactly once even with req held high 20 cycles.
3. After init, host read addr 65 with bus_rdata = 16'h0002 → bus_re one cycle after accept; host_rdata = 2 and host_ack the following cycle; total latency 2 cycles.
4. init_start pulsed in the same cycle a host read is accepted → read completes with ack, then hwag_en drops and 131 writes replay starting at addr 0.
5. rst pulled low at load index 40, then released → no strobe while low; all outputs 0; the reload starts at addr 0 and completes 262 cycles later.
6. Back-to-back host writes with req low for 1 cycle between → two distinct bus_we pulses and two host_ack pulses, 3 cycles apart.
